// File: rtl/fridge_ctrl_pkg.sv
// Shared definitions for the fridge controller datapath.
//   comp_state_t : compressor protection FSM encoding (LOCKOUT=0, IDLE=1, START=2, RUN=3)
//   Q88_ONE      : 1.0 in signed Q8.8
//   DUTY_MAX     : full-scale 8-bit PWM duty (100 % high)
package fridge_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_START   = 2'd2,
        ST_RUN     = 2'd3
    } comp_state_t;

    localparam logic signed [15:0] Q88_ONE  = 16'sh0100;
    localparam logic        [7:0]  DUTY_MAX = 8'd255;

endpackage

// File: rtl/compressor_pwm_driver_if.sv
// PID sample bus between pid_controller and compressor_pwm_driver.
//   pid_out   : signed Q8.8 controller output
//   pid_valid : 1-cycle strobe, pid_out holds a new sample
// master = pid_controller side (drives), slave = driver side (receives).
interface compressor_pwm_driver_if;

    logic signed [15:0] pid_out;
    logic               pid_valid;

    modport master (output pid_out, output pid_valid);
    modport slave  (input  pid_out, input  pid_valid);

endinterface

// File: rtl/compressor_pwm_driver_pwm_gen.sv
// 8-bit PWM generator with a 256-clk period.
//   clk, rst     : clock, asynchronous active-high reset
//   duty_target  : requested duty, sampled only when a new period begins
//   force_zero   : drops duty_applied and pwm_out to 0 on the next clk
//   duty_applied : duty currently used by the comparator
//   pwm_out      : registered (cnt < duty_applied) || (duty_applied == 255)
module pwm_gen
    import fridge_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty_target,
    input  logic       force_zero,
    output logic [7:0] duty_applied,
    output logic       pwm_out
);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] duty_nxt;

    // A new target is taken only when the counter is about to wrap to 0,
    // so a period is never cut short or stretched by a mid-period change.
    always_comb begin
        cnt_nxt  = cnt + 8'd1;
        duty_nxt = duty_applied;
        if (force_zero) begin
            duty_nxt = 8'd0;
        end else if (cnt_nxt == 8'd0) begin
            duty_nxt = duty_target;
        end
    end

    // Output is computed from the next counter/duty values and registered,
    // so pwm_out always matches the registered cnt/duty_applied pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 8'd0;
            duty_applied <= 8'd0;
            pwm_out      <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            duty_applied <= duty_nxt;
            pwm_out      <= (cnt_nxt < duty_nxt) || (duty_nxt == DUTY_MAX);
        end
    end

endmodule

// File: rtl/compressor_pwm_driver.sv
// Compressor driver: converts the signed Q8.8 PID output into a relay enable and
// a PWM speed command while enforcing min-off lockout, min-on soft-start,
// start/stop hysteresis and fault shutdown.
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : driver enable
//   pid_if        : PID sample bus (pid_out, pid_valid)
//   fault         : compressor fault level input
//   fault_clr     : strobe, clears fault_latched when fault is low
//   comp_en       : compressor relay enable (registered from next state)
//   pwm_out       : PWM speed command
//   duty_applied  : duty used by the PWM generator
//   state         : protection FSM state
//   fault_latched : sticky fault flag
module compressor_pwm_driver
    import fridge_ctrl_pkg::*;
#(
    parameter bit          DEMAND_INVERT = 1'b1,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned MIN_OFF_TICKS = 180000,
    parameter int unsigned MIN_ON_TICKS  = 60000,
    parameter logic [7:0]  START_THRESH  = 8'd64,
    parameter logic [7:0]  STOP_THRESH   = 8'd16,
    parameter logic [7:0]  START_DUTY    = 8'd128,
    parameter logic [7:0]  MIN_RUN_DUTY  = 8'd32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    compressor_pwm_driver_if.slave        pid_if,
    input  logic                          fault,
    input  logic                          fault_clr,
    output logic                          comp_en,
    output logic                          pwm_out,
    output logic [7:0]                    duty_applied,
    output logic [1:0]                    state,
    output logic                          fault_latched
);

    localparam int unsigned TICK_W    = $clog2(TICK_DIV);
    localparam int unsigned TIMER_SAT = (MIN_OFF_TICKS > MIN_ON_TICKS) ? MIN_OFF_TICKS : MIN_ON_TICKS;
    localparam int unsigned TIMER_W   = $clog2(TIMER_SAT + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] TMR_SAT   = TIMER_W'(TIMER_SAT);
    localparam logic [TIMER_W-1:0] OFF_T     = TIMER_W'(MIN_OFF_TICKS);
    localparam logic [TIMER_W-1:0] ON_T      = TIMER_W'(MIN_ON_TICKS);

    // Signed demand -> 8-bit duty request, clamped to [0, 1.0).
    function automatic logic [7:0] demand_to_duty(input logic signed [15:0] pid);
        logic signed [16:0] ext;
        logic signed [16:0] d;
        ext = {pid[15], pid};
        d   = DEMAND_INVERT ? -ext : ext;   // 17 bits: -(-32768) stays positive
        if (d <= 17'sd0) begin
            return 8'd0;
        end else if (d >= $signed({1'b0, Q88_ONE})) begin
            return DUTY_MAX;
        end else begin
            return d[7:0];
        end
    endfunction

    function automatic logic [7:0] run_duty(input logic [7:0] req);
        return (req < MIN_RUN_DUTY) ? MIN_RUN_DUTY : req;
    endfunction

    comp_state_t         st;
    comp_state_t         st_nxt;
    logic [7:0]          duty_req_p1;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [TIMER_W-1:0]  timer;
    logic                entry;
    logic                comp_en_nxt;
    logic [7:0]          duty_target;
    logic                force_zero;

    // ---- stage p1: demand register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_req_p1 <= 8'd0;
        end else if (pid_if.pid_valid && enable) begin
            duty_req_p1 <= demand_to_duty(pid_if.pid_out);
        end
    end

    // ---- timebase and protection timer ----
    assign tick = (tick_cnt == TICK_LAST);

    // A fault restarts the off-time even when already in LOCKOUT, so the
    // minimum off period is always measured from the last fault.
    assign entry = (st_nxt != st) || fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            timer    <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (entry) begin
                timer <= '0;
            end else if (tick && (timer != TMR_SAT)) begin
                timer <= timer + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

    // ---- protection FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_LOCKOUT;
            comp_en <= 1'b0;
        end else begin
            st      <= st_nxt;
            comp_en <= comp_en_nxt;
        end
    end

    // ---- protection FSM: next state ----
    always_comb begin
        st_nxt = st;
        case (st)
            ST_LOCKOUT: if ((timer >= OFF_T) && !fault_latched)          st_nxt = ST_IDLE;
            ST_IDLE:    if (enable && (duty_req_p1 >= START_THRESH))     st_nxt = ST_START;
            ST_START:   if (timer >= ON_T)                               st_nxt = ST_RUN;
            ST_RUN:     if (!enable || (duty_req_p1 < STOP_THRESH))      st_nxt = ST_LOCKOUT;
            default:                                                     st_nxt = ST_LOCKOUT;
        endcase
        if (fault) begin
            st_nxt = ST_LOCKOUT;
        end
    end

    // ---- protection FSM: outputs (decoded from next state) ----
    always_comb begin
        comp_en_nxt = 1'b0;
        duty_target = 8'd0;
        force_zero  = 1'b1;
        case (st_nxt)
            ST_START: begin
                comp_en_nxt = 1'b1;
                duty_target = START_DUTY;
                force_zero  = 1'b0;
            end
            ST_RUN: begin
                comp_en_nxt = 1'b1;
                duty_target = run_duty(duty_req_p1);
                force_zero  = 1'b0;
            end
            default: ;
        endcase
    end

    assign state = st;

    // ---- PWM output stage ----
    pwm_gen u_pwm_gen (
        .clk          (clk),
        .rst          (rst),
        .duty_target  (duty_target),
        .force_zero   (force_zero),
        .duty_applied (duty_applied),
        .pwm_out      (pwm_out)
    );

endmodule
